mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of EX in the 32-bit LoongArch pipeline.
- Consumes the EX result: ALU_out as the address or result, forwarded store data, the memory opcode and write-back control.
- Runs load/store transactions on a req/gnt/rvalid data-memory bus and delivers one registered result per instruction to WB.
- Stalls EX (in_ready low) while a memory transaction is outstanding.

Parameters:
- WORD, 32, datapath and address width.
- REG_LOG, 5, register index width.

Ports:
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  EX presents an instruction.
- in_ready  out  1  stage can accept; combinational, = (state==IDLE).
- in_PC  in  WORD  instruction PC.
- in_ALU_out  in  WORD  ALU result, or effective address for ld/st.
- in_store_data  in  WORD  forwarded store source (rd value).
- in_mem_op  in  4  0000 none, 0001 ld.b, 0010 ld.h, 0011 ld.w, 0100 ld.bu, 0101 ld.hu, 1000 st.b, 1001 st.h, 1010 st.w; any other code is treated as none.
- in_rd  in  REG_LOG  destination register.
- in_reg_we  in  1  destination write enable.
- out_valid  out  1  result valid for WB; a one-cycle pulse per instruction.
- out_PC  out  WORD  PC of the retiring instruction.
- out_result  out  WORD  ALU result or load data; also the MEM forwarding source to EX.
- out_rd  out  REG_LOG  destination register.
- out_reg_we  out  1  write enable; forced 0 for stores.
- out_ale  out  1  address-alignment exception flag.
- dmem_req  out  1  bus request; held until gnt.
- dmem_we  out  1  1 = store.
- dmem_addr  out  WORD  word-aligned address, {addr[31:2],2'b00}.
- dmem_wstrb  out  4  byte strobes.
- dmem_wdata  out  WORD  lane-replicated store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  WORD  load data word.

Behaviour:
- Reset (sync, rst=1 at a posedge):
  - state goes to IDLE.
  - All out_* go to 0.
  - dmem_req, dmem_we, dmem_wstrb go to 0.
  - Reset mid-transaction abandons the transaction with no output; the bus must tolerate a dropped request.
- FSM states: IDLE, REQ, WAIT.
- IDLE, in_valid=1, op = none:
  - out_* registered at this edge; out_valid=1 the next cycle.
  - out_result = in_ALU_out; out_reg_we = in_reg_we.
  - Back-to-back non-memory instructions sustain 1 per cycle.
- IDLE, in_valid=1, op = ld/st:
  - Capture PC, address, store data, op, rd, we.
  - Go to REQ; out_valid=0 the next cycle.
- REQ:
  - dmem_req=1; address, strobes and data stay stable until gnt.
  - On gnt for a store: out_valid=1 next cycle with out_reg_we=0; go to IDLE.
  - On gnt for a load: go to WAIT.
- WAIT:
  - dmem_req=0.
  - On rvalid: out_result = extracted load data, out_valid=1 next cycle; go to IDLE.
  - rvalid seen outside WAIT is ignored.
- Minimum load latency: accept at edge 0, gnt in cycle 1, rvalid in cycle 2, out_valid in cycle 3. Minimum store latency: 2 cycles.
- Store formatting:
  - st.b: wdata = {4{d[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - st.h: wdata = {2{d[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - st.w: wdata = d, wstrb = 1111.
  - Loads: wstrb = 0000.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - ld.b / ld.h sign-extend; ld.bu / ld.hu zero-extend; ld.w passes the word through.
- out_valid drops to 0 in every cycle that does not retire an instruction. out_* fields hold their last value while out_valid=0.
- No flush input: the instruction in MEM is always older than any branch resolved in EX.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- With the macro defined:
  - Misaligned access is ld.h/ld.hu/st.h with addr[0]=1, or ld.w/st.w with addr[1:0]≠00.
  - Such an access issues no bus request and stays in IDLE.
  - out_valid=1 next cycle with out_ale=1, out_reg_we=0, out_result = address.
- Without the macro:
  - out_ale is tied 0.
  - Low address bits below the access size are ignored; the access is aligned down.

Test Plan:
- ALU ops 0x11, 0x22, 0x33 on consecutive cycles -> in_ready stays 1; out_result = 0x11, 0x22, 0x33 on consecutive cycles.
- st.b, addr 0x1003, data 0x000000A5, gnt after 2 REQ cycles -> dmem_wstrb=1000, dmem_wdata=0xA5A5A5A5, dmem_addr=0x1000, req held 2 cycles; out_valid with out_reg_we=0; in_ready low meanwhile.
- ld.b / ld.bu, addr 0x2002, rdata 0x0080FF00 -> out_result 0xFFFFFF80 / 0x00000080. ld.hu, addr 0x2002 -> 0x00000080.
- Load with gnt in cycle 1 and rvalid delayed to cycle 5 -> out_valid exactly once, in cycle 6. No spurious out_valid; EX stalled through cycle 5.
- rst asserted during WAIT -> next cycle state=IDLE, dmem_req=0, out_valid=0; a later rvalid produces no output.
- MEM_ALIGN_CHECK_EN defined, ld.w at 0x3002 -> no dmem_req; out_ale=1, out_reg_we=0, out_result=0x3002 next cycle. Macro undefined, same input -> dmem_addr=0x3000, normal load.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// A request is held until gnt; load data returns later on rvalid.
interface mem_stage_if #(
    parameter int WORD = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [WORD-1:0] dmem_addr;
    logic [3:0]      dmem_wstrb;
    logic [WORD-1:0] dmem_wdata;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [WORD-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 32-bit LoongArch pipeline: passes ALU results through in one
// cycle, runs loads/stores on the req/gnt/rvalid bus and stalls EX meanwhile.
// Optional macro MEM_ALIGN_CHECK_EN: misaligned h/w accesses retire at once with
// out_ale=1 instead of touching the bus. Without it out_ale never rises and low
// address bits below the access size are ignored.
module mem_stage #(
    parameter int WORD    = 32,
    parameter int REG_LOG = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD-1:0]    in_PC,
    input  logic [WORD-1:0]    in_ALU_out,
    input  logic [WORD-1:0]    in_store_data,
    input  logic [3:0]         in_mem_op,
    input  logic [REG_LOG-1:0] in_rd,
    input  logic               in_reg_we,
    output logic               out_valid,
    output logic [WORD-1:0]    out_PC,
    output logic [WORD-1:0]    out_result,
    output logic [REG_LOG-1:0] out_rd,
    output logic               out_reg_we,
    output logic               out_ale,
    mem_stage_if.master        dmem
);
    localparam logic [3:0] LD_B  = 4'b0001;
    localparam logic [3:0] LD_H  = 4'b0010;
    localparam logic [3:0] LD_W  = 4'b0011;
    localparam logic [3:0] LD_BU = 4'b0100;
    localparam logic [3:0] LD_HU = 4'b0101;
    localparam logic [3:0] ST_B  = 4'b1000;
    localparam logic [3:0] ST_H  = 4'b1001;
    localparam logic [3:0] ST_W  = 4'b1010;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state;

    // Transaction context held while the bus is busy
    logic [WORD-1:0]    cap_pc;
    logic [WORD-1:0]    cap_addr;
    logic [3:0]         cap_op;
    logic [REG_LOG-1:0] cap_rd;
    logic               cap_we;

    logic               is_ld, is_st;
    logic [WORD-1:0]    st_wdata;
    logic [3:0]         st_wstrb;

    assign in_ready = (state == IDLE);

    // Opcode class and store lane formatting from the incoming EX result
    always_comb begin
        is_ld    = (in_mem_op >= LD_B) && (in_mem_op <= LD_HU);
        is_st    = (in_mem_op >= ST_B) && (in_mem_op <= ST_W);
        st_wdata = in_store_data;
        st_wstrb = 4'b0000;
        case (in_mem_op)
            ST_B: begin
                st_wdata = {4{in_store_data[7:0]}};
                st_wstrb = 4'b0001 << in_ALU_out[1:0];
            end
            ST_H: begin
                st_wdata = {2{in_store_data[15:0]}};
                st_wstrb = in_ALU_out[1] ? 4'b1100 : 4'b0011;
            end
            ST_W:    st_wstrb = 4'b1111;
            default: st_wstrb = 4'b0000;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign;

    // Halfword accesses need addr[0]=0, word accesses addr[1:0]=00
    always_comb begin
        misalign = 1'b0;
        case (in_mem_op)
            LD_H, LD_HU, ST_H: misalign = in_ALU_out[0];
            LD_W, ST_W:        misalign = |in_ALU_out[1:0];
            default:           misalign = 1'b0;
        endcase
    end
`endif

    // Pick the addressed byte/half out of the returned word and extend it
    function automatic logic [WORD-1:0] load_extract(input logic [3:0] op,
                                                     input logic [1:0] lane,
                                                     input logic [WORD-1:0] w);
        logic [WORD-1:0] sh;
        logic [7:0]      b;
        logic [15:0]     h;
        logic [WORD-1:0] r;
        sh = w >> {lane, 3'b000};
        b  = sh[7:0];
        h  = lane[1] ? w[31:16] : w[15:0];
        case (op)
            LD_B:    r = {{24{b[7]}}, b};
            LD_BU:   r = {24'd0, b};
            LD_H:    r = {{16{h[15]}}, h};
            LD_HU:   r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Stage FSM: bus control, transaction capture and the registered WB result
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            out_valid       <= 1'b0;
            out_PC          <= '0;
            out_result      <= '0;
            out_rd          <= '0;
            out_reg_we      <= 1'b0;
            out_ale         <= 1'b0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_wstrb <= 4'b0000;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            cap_pc          <= '0;
            cap_addr        <= '0;
            cap_op          <= 4'b0000;
            cap_rd          <= '0;
            cap_we          <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef MEM_ALIGN_CHECK_EN
                        if (misalign) begin
                            out_valid  <= 1'b1;
                            out_PC     <= in_PC;
                            out_result <= in_ALU_out;
                            out_rd     <= in_rd;
                            out_reg_we <= 1'b0;
                            out_ale    <= 1'b1;
                        end else
`endif
                        if (is_ld || is_st) begin
                            cap_pc          <= in_PC;
                            cap_addr        <= in_ALU_out;
                            cap_op          <= in_mem_op;
                            cap_rd          <= in_rd;
                            cap_we          <= in_reg_we;
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= is_st;
                            dmem.dmem_addr  <= {in_ALU_out[WORD-1:2], 2'b00};
                            dmem.dmem_wstrb <= st_wstrb;
                            dmem.dmem_wdata <= st_wdata;
                            state           <= REQ;
                        end else begin
                            out_valid  <= 1'b1;
                            out_PC     <= in_PC;
                            out_result <= in_ALU_out;
                            out_rd     <= in_rd;
                            out_reg_we <= in_reg_we;
                            out_ale    <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (dmem.dmem_gnt) begin
                        dmem.dmem_req <= 1'b0;
                        if (dmem.dmem_we) begin
                            out_valid  <= 1'b1;
                            out_PC     <= cap_pc;
                            out_result <= cap_addr;
                            out_rd     <= cap_rd;
                            out_reg_we <= 1'b0;
                            out_ale    <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem.dmem_rvalid) begin
                        out_valid  <= 1'b1;
                        out_PC     <= cap_pc;
                        out_result <= load_extract(cap_op, cap_addr[1:0], dmem.dmem_rdata);
                        out_rd     <= cap_rd;
                        out_reg_we <= cap_we;
                        out_ale    <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases then randomized ops, each
// checked against a reference computed from the lane/extension rules.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_PC, in_ALU_out, in_store_data;
    logic [3:0]  in_mem_op;
    logic [4:0]  in_rd;
    logic        in_reg_we;
    logic        out_valid;
    logic [31:0] out_PC, out_result;
    logic [4:0]  out_rd;
    logic        out_reg_we, out_ale;

    int vectors     = 0;
    int miscompares = 0;

    mem_stage_if bus ();

    mem_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_PC(in_PC),
        .in_ALU_out(in_ALU_out), .in_store_data(in_store_data),
        .in_mem_op(in_mem_op), .in_rd(in_rd), .in_reg_we(in_reg_we),
        .out_valid(out_valid), .out_PC(out_PC), .out_result(out_result),
        .out_rd(out_rd), .out_reg_we(out_reg_we), .out_ale(out_ale),
        .dmem(bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w / (32'd1 << (8 * (addr % 4)))) % 256;
        h = (w / (32'd1 << (16 * ((addr / 2) % 2)))) % 65536;
        case (op)
            4'd1:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            4'd4:    return b;
            4'd2:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            4'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_wstrb(input logic [3:0] op, input logic [31:0] addr);
        case (op)
            4'd8:    return 32'd1 << (addr % 4);
            4'd9:    return 32'd3 << (2 * ((addr / 2) % 2));
            4'd10:   return 32'd15;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] d);
        case (op)
            4'd8:    return (d % 256) * 32'h01010101;
            4'd9:    return (d % 65536) * 32'h00010001;
            default: return d;
        endcase
    endfunction

`ifdef MEM_ALIGN_CHECK_EN
    function automatic bit ref_misalign(input logic [3:0] op, input logic [31:0] addr);
        return ((op == 4'd2 || op == 4'd5 || op == 4'd9) && (addr % 2 != 0)) ||
               ((op == 4'd3 || op == 4'd10) && (addr % 4 != 0));
    endfunction
`endif

    // One instruction from EX through retirement, bus driven with given delays
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] pc,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input logic we, input int gd,
                          input int rdly, input logic [31:0] rdata);
        bit ld, st, mis;
        logic [31:0] exp_res;
        ld  = (op >= 4'd1) && (op <= 4'd5);
        st  = (op >= 4'd8) && (op <= 4'd10);
        mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        mis = ref_misalign(op, addr);
`endif
        chk({tag, " in_ready"}, in_ready, 1);
        in_valid = 1'b1; in_PC = pc; in_ALU_out = addr; in_store_data = data;
        in_mem_op = op; in_rd = rd; in_reg_we = we;
        tick();
        in_valid = 1'b0; in_ALU_out = $urandom; in_store_data = $urandom;
        in_mem_op = 4'($urandom); in_PC = $urandom;
        if (!(ld || st) || mis) begin
            chk({tag, " out_valid"}, out_valid, 1);
            chk({tag, " out_result"}, out_result, addr);
            chk({tag, " out_reg_we"}, out_reg_we, mis ? 1'b0 : we);
            chk({tag, " out_rd"}, out_rd, rd);
            chk({tag, " out_PC"}, out_PC, pc);
            chk({tag, " out_ale"}, out_ale, mis);
            chk({tag, " dmem_req"}, bus.dmem_req, 0);
            return;
        end
        for (int k = 0; k <= gd; k++) begin
            chk({tag, " req held"}, bus.dmem_req, 1);
            chk({tag, " dmem_addr"}, bus.dmem_addr, addr & ~32'd3);
            chk({tag, " dmem_we"}, bus.dmem_we, st);
            chk({tag, " dmem_wstrb"}, bus.dmem_wstrb, ref_wstrb(op, addr));
            if (st) chk({tag, " dmem_wdata"}, bus.dmem_wdata, ref_wdata(op, data));
            chk({tag, " stall"}, in_ready, 0);
            chk({tag, " no early valid"}, out_valid, 0);
            if (k == gd) bus.dmem_gnt = 1'b1;
            tick();
            bus.dmem_gnt = 1'b0;
        end
        exp_res = 32'd0;
        if (ld) begin
            for (int k = 0; k <= rdly; k++) begin
                chk({tag, " wait req low"}, bus.dmem_req, 0);
                chk({tag, " wait no valid"}, out_valid, 0);
                chk({tag, " wait stall"}, in_ready, 0);
                if (k == rdly) begin
                    bus.dmem_rvalid = 1'b1;
                    bus.dmem_rdata  = rdata;
                end
                tick();
                bus.dmem_rvalid = 1'b0;
                bus.dmem_rdata  = $urandom;
            end
            exp_res = ref_load(op, addr, rdata);
        end
        chk({tag, " retire valid"}, out_valid, 1);
        if (ld) chk({tag, " load result"}, out_result, exp_res);
        chk({tag, " retire reg_we"}, out_reg_we, ld ? we : 1'b0);
        chk({tag, " retire rd"}, out_rd, rd);
        chk({tag, " retire PC"}, out_PC, pc);
        chk({tag, " retire ale"}, out_ale, 0);
        chk({tag, " ready again"}, in_ready, 1);
    endtask

    initial begin
        logic [3:0] ops [11];
        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd7, 4'd12};
        rst = 1'b1; in_valid = 1'b0; in_PC = '0; in_ALU_out = '0; in_store_data = '0;
        in_mem_op = '0; in_rd = '0; in_reg_we = 1'b0;
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset out_valid", out_valid, 0);
        chk("reset out_result", out_result, 0);
        chk("reset out_reg_we", out_reg_we, 0);
        chk("reset dmem_req", bus.dmem_req, 0);
        chk("reset dmem_wstrb", bus.dmem_wstrb, 0);
        chk("reset in_ready", in_ready, 1);

        // back-to-back ALU results, one per cycle
        run_op("alu0", 4'd0, 32'h100, 32'h11, 32'h0, 5'd1, 1'b1, 0, 0, 0);
        run_op("alu1", 4'd0, 32'h104, 32'h22, 32'h0, 5'd2, 1'b1, 0, 0, 0);
        run_op("alu2", 4'd0, 32'h108, 32'h33, 32'h0, 5'd3, 1'b0, 0, 0, 0);
        tick();
        chk("alu pulse drop", out_valid, 0);
        chk("alu hold result", out_result, 32'h33);

        run_op("st.b", 4'd8, 32'h200, 32'h1003, 32'h000000A5, 5'd4, 1'b1, 1, 0, 0);
        chk("st.b wstrb value", bus.dmem_wstrb, 4'b1000);
        run_op("ld.b", 4'd1, 32'h204, 32'h2002, 32'h0, 5'd5, 1'b1, 0, 0, 32'h0080FF00);
        chk("ld.b value", out_result, 32'hFFFFFF80);
        run_op("ld.bu", 4'd4, 32'h208, 32'h2002, 32'h0, 5'd6, 1'b1, 0, 0, 32'h0080FF00);
        chk("ld.bu value", out_result, 32'h00000080);
        run_op("ld.hu", 4'd5, 32'h20C, 32'h2002, 32'h0, 5'd7, 1'b1, 0, 0, 32'h0080FF00);
        chk("ld.hu value", out_result, 32'h00000080);
        run_op("ld.w slow", 4'd3, 32'h210, 32'h2004, 32'h0, 5'd8, 1'b1, 0, 3, 32'hCAFEF00D);
        tick();
        chk("ld.w single pulse", out_valid, 0);
        run_op("ld.w 3002", 4'd3, 32'h214, 32'h3002, 32'h0, 5'd9, 1'b1, 0, 0, 32'h12345678);

        // reset while waiting for load data abandons the load
        in_valid = 1'b1; in_mem_op = 4'd3; in_ALU_out = 32'h4000; in_rd = 5'd10; in_reg_we = 1'b1;
        tick();
        in_valid = 1'b0; bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        chk("rst-wait stalled", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst-wait ready", in_ready, 1);
        chk("rst-wait req", bus.dmem_req, 0);
        chk("rst-wait valid", out_valid, 0);
        chk("rst-wait result", out_result, 0);
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hDEADBEEF;
        tick();
        bus.dmem_rvalid = 1'b0;
        chk("stray rvalid", out_valid, 0);

        // randomized mix against the reference rules
        for (int i = 0; i < 60; i++) begin
            run_op("rand", ops[$urandom_range(0, 10)], $urandom, $urandom, $urandom,
                   5'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom);
            if ($urandom_range(0, 3) == 0) begin
                tick();
                chk("rand idle", out_valid, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
